// File: rtl/arb4_rr_b16_if.sv
// arb4_rr_b16_if: four producer beats in, one valid/ready channel out, grant status back
interface arb4_rr_b16_if;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [15:0] d0;
  logic [15:0] d1;
  logic [15:0] d2;
  logic [15:0] d3;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic [3:0]  ack;
  logic        busy;
  modport master (
    output req, last, d0, d1, d2, d3, out_ready,
    input  gnt, sel, out_valid, out_data, out_last, ack, busy
  );
  modport slave (
    input  req, last, d0, d1, d2, d3, out_ready,
    output gnt, sel, out_valid, out_data, out_last, ack, busy
  );
endinterface

// File: rtl/arb4_rr_b16.sv
// arb4_rr_b16: round-robin packet arbiter for four 16-bit producers with a burst cap
module arb4_rr_b16 #(
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 8
) (
  input logic          clk,
  input logic          rst_n,
  arb4_rr_b16_if.slave bus
);
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d, ptr_q, ptr_d, base, pick;
  logic [3:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy, xfer, rel;
  assign busy          = state_q == GRANTED;
  assign bus.busy      = busy;
  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = bus.req[sel_q] & busy;
  assign bus.out_data  = sel_q == 2'd0 ? bus.d0 : sel_q == 2'd1 ? bus.d1 : sel_q == 2'd2 ? bus.d2 : bus.d3;
  assign bus.out_last  = (bus.last[sel_q] | cnt_q == CNT_W'(MAX_BURST - 1)) & busy;
  assign xfer          = bus.out_valid & bus.out_ready;
  assign bus.ack       = gnt_q & {4{xfer}};
  // a grant ends on its last (or capped) beat, or when the owner withdraws req without transferring
  assign rel           = busy & ((xfer & bus.out_last) | ~bus.req[sel_q]);
  // rotating priority search: at release the order already starts after the outgoing owner
  always_comb begin
    base = busy ? sel_q + 2'd1 : ptr_q;
    pick = '0;
    for (int k = 3; k >= 0; k--)
      if (bus.req[2'(base + 2'(k))]) pick = 2'(base + 2'(k));
  end
  // grant FSM: claim, count beats, release and re-arbitrate in the same edge
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (!busy) begin
      if (|bus.req) begin
        state_d = GRANTED;
        sel_d   = pick;
        cnt_d   = '0;
      end
    end else if (rel) begin
      ptr_d   = sel_q + 2'd1;
      cnt_d   = '0;
      state_d = |bus.req ? GRANTED : IDLE;
      sel_d   = |bus.req ? pick : sel_q;
    end else if (xfer) begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
    gnt_d = state_d == GRANTED ? 4'(1) << sel_d : 4'b0000;
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end
endmodule
